// File: rtl/freq_scaler.sv
// freq_scaler: divides clk_50MHz by DIV into a 50 % duty clk_1MHz with an optional rise strobe
// Ports: clk_50MHz (system clock), rst (sync, active-high), en (count enable),
//        clk_1MHz (divided clock, registered), tick_1MHz (one-cycle strobe on each
//        clk_1MHz rise, registered), cnt (phase counter 0..DIV-1).
// Build option: define FREQ_SCALER_TICK_EN to build the tick_1MHz flop; otherwise it is tied to 0.
module freq_scaler #(
  parameter int DIV = 50,
  parameter int CW = $clog2(DIV)
) (
  input  logic          clk_50MHz,
  input  logic          rst,
  input  logic          en,
  output logic          clk_1MHz,
  output logic          tick_1MHz,
  output logic [CW-1:0] cnt
);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  if (DIV < 2 || DIV % 2 != 0) begin : g_bad_div
    $error("freq_scaler: DIV must be even and >= 2");
  end
  logic [CW-1:0] cnt_next;
  always_comb cnt_next = !en ? cnt : (cnt == LAST) ? '0 : cnt + CW'(1);
  // clk_1MHz is decoded from the value being loaded, so it changes on the same edge as cnt
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      cnt      <= '0;
      clk_1MHz <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      clk_1MHz <= cnt_next >= HALF;
    end
  end
`ifdef FREQ_SCALER_TICK_EN
  always_ff @(posedge clk_50MHz) begin
    if (rst) tick_1MHz <= 1'b0;
    else tick_1MHz <= en && cnt_next == HALF && cnt == HALF - CW'(1);
  end
`else
  assign tick_1MHz = 1'b0;
`endif
endmodule

// File: tb/tb_freq_scaler.sv
// tb_freq_scaler: directed self-checking bench for freq_scaler (DIV=50 and DIV=2 instances)
module tb_freq_scaler;
`ifdef FREQ_SCALER_TICK_EN
  localparam int TICK = 1;
`else
  localparam int TICK = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, rst2 = 1'b1, en2 = 1'b0;
  logic clk_1MHz, tick_1MHz, clk2, tick2;
  logic [5:0] cnt;
  logic [0:0] cnt2;
  int total = 0, bad = 0;
  always #10 clk = ~clk;
  freq_scaler u_dut (.clk_50MHz(clk), .rst(rst), .en(en), .clk_1MHz(clk_1MHz), .tick_1MHz(tick_1MHz), .cnt(cnt));
  freq_scaler #(.DIV(2)) u_div2 (.clk_50MHz(clk), .rst(rst2), .en(en2), .clk_1MHz(clk2), .tick_1MHz(tick2), .cnt(cnt2));
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_clk", int'(clk_1MHz), 0);
      chk("rst_tick", int'(tick_1MHz), 0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      chk("run_cnt", int'(cnt), k % 50);
      chk("run_clk", int'(clk_1MHz), int'(k % 50 >= 25));
      chk("run_tick", int'(tick_1MHz), (TICK != 0 && k % 50 == 25) ? 1 : 0);
    end
    repeat (30) step();
    chk("pre_hold_cnt", int'(cnt), 30);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_cnt", int'(cnt), 30);
      chk("hold_clk", int'(clk_1MHz), 1);
      chk("hold_tick", int'(tick_1MHz), 0);
    end
    en = 1'b1;
    for (n = 1; n <= 100; n++) begin
      step();
      if (!clk_1MHz) break;
    end
    chk("resume_fall_edges", n, 20);
    chk("resume_fall_cnt", int'(cnt), 0);
    repeat (40) step();
    chk("pre_rst_cnt", int'(cnt), 40);
    chk("pre_rst_clk", int'(clk_1MHz), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_cnt", int'(cnt), 0);
    chk("mid_rst_clk", int'(clk_1MHz), 0);
    chk("mid_rst_tick", int'(tick_1MHz), 0);
    rst = 1'b0;
    for (n = 1; n <= 100; n++) begin
      step();
      if (clk_1MHz) break;
    end
    chk("post_rst_rise_edges", n, 25);
    chk("post_rst_rise_tick", int'(tick_1MHz), TICK);
    step();
    chk("post_rise_tick_clear", int'(tick_1MHz), 0);
    step();
    chk("div2_rst_cnt", int'(cnt2), 0);
    chk("div2_rst_clk", int'(clk2), 0);
    rst2 = 1'b0;
    en2 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("div2_cnt", int'(cnt2), k % 2);
      chk("div2_clk", int'(clk2), k % 2);
      chk("div2_tick", int'(tick2), TICK != 0 ? k % 2 : 0);
    end
    en2 = 1'b0;
    step();
    chk("div2_hold_clk", int'(clk2), 0);
    chk("div2_hold_tick", int'(tick2), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/freq_scaler.md
# freq_scaler

Integer clock divider that derives a 1 MHz, 50 %-duty clock from the 50 MHz system clock. It uses a registered modulo counter with no combinational path from the counter to the divided-clock output. The block sits at the front of the PWM counter path and supplies its time base. The divided output is a fabric signal, not a clock-tree root. Downstream logic on `clk_50MHz` uses the optional `tick_1MHz` strobe as a clock enable instead.

## Interface
- `DIV`, default 50: division ratio. Must be even and ≥ 2; any other value is a configuration error.
- `CW`, default `$clog2(DIV)`: counter width. Derived; not overridden.

- `clk_50MHz`  in  1  system clock, 50 MHz; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  count enable; when low, all state holds.
- `clk_1MHz`  out  1  divided clock, registered, period `DIV` input cycles, 50 % duty.
- `tick_1MHz`  out  1  one-cycle strobe marking each rising edge of `clk_1MHz`, registered.
- `cnt`  out  `CW`  current phase counter value, 0..`DIV`-1, for debug and phase alignment.

## Operation
- **Counter.** `cnt` is a modulo-`DIV` counter.
  - When `en`=1: `cnt` ← 0 if `cnt` = `DIV`-1, else `cnt`+1.
  - When `en`=0: `cnt` holds.
- **Divided clock.** `clk_1MHz` is registered as `(cnt_next ≥ DIV/2)`, where `cnt_next` is the counter value being loaded on the same edge. The output is therefore low for `cnt` 0..`DIV/2`-1 and high for `cnt` `DIV/2`..`DIV`-1.
- **Tick.** `tick_1MHz` is registered as `en & (cnt_next == DIV/2) & (cnt == DIV/2-1)`. It is high for exactly one `clk_50MHz` cycle, in the same cycle `clk_1MHz` first reads 1.
- **Reset.** When `rst`=1 at a rising edge: `cnt`=0, `clk_1MHz`=0, `tick_1MHz`=0.
  - `rst` takes priority over `en`.
  - Reset asserted mid-period truncates the current period immediately; no glitch beyond the registered 1→0 transition.
- **Wrap-around.** `DIV`-1 → 0 wraps the counter; `clk_1MHz` falls on that same edge.
- **Enable.** Dropping `en` freezes the phase. Re-asserting `en` resumes from the frozen phase; no cycles are lost or duplicated.
- **Edge case `DIV`=2.** `clk_1MHz` toggles every enabled cycle, and `tick_1MHz` is high on every cycle where `clk_1MHz` rises.

## Timing
- All outputs are flops clocked by `clk_50MHz`; there is zero combinational input-to-output path.
- With `en`=1 held from the first edge after `rst` deasserts, counting that edge as edge 1:
  - `clk_1MHz` rises on edge `DIV/2` (25).
  - `clk_1MHz` falls on edge `DIV` (50).
  - The pattern then repeats every `DIV` edges (1000 ns).
- High time and low time are each exactly `DIV/2` input cycles (500 ns at defaults).
- `tick_1MHz` asserts on edges 25, 75, 125, … and is 0 on all other edges.
- Reset latency is 1 edge. The first rising edge of `clk_1MHz` after reset occurs `DIV/2` enabled edges later.

## Configuration
- **`FREQ_SCALER_TICK_EN` defined:** the `tick_1MHz` flop and its logic are built as described in Operation.
- **`FREQ_SCALER_TICK_EN` undefined:**
  - `tick_1MHz` is tied to constant 0 and no flop is inferred.
  - `clk_1MHz` and `cnt` behaviour is unchanged.
  - The port list is the same in both builds.

## Test plan
- **Reset, then run.** 50 MHz clock, `rst`=1 for 3 cycles, then `rst`=0, `en`=1 for 2000 ns → `clk_1MHz` period 1000 ns, high 500 ns, first rise on edge 25. `cnt` sequence is 0..49, wrap to 0.
- **Tick (`FREQ_SCALER_TICK_EN` defined).** Same stimulus → `tick_1MHz` high exactly on edges 25 and 75, one cycle each, coincident with `clk_1MHz` 0→1. With the macro undefined → `tick_1MHz` is 0 throughout.
- **Enable hold.** Drop `en` at `cnt`=30 for 10 cycles → `cnt` stays 30, `clk_1MHz` stays 1. On resume, the fall occurs 20 enabled edges later.
- **Mid-period reset.** Assert `rst` at `cnt`=40 (`clk_1MHz`=1) → next edge gives `cnt`=0, `clk_1MHz`=0, `tick_1MHz`=0. The next rise is 25 enabled edges after `rst` deasserts.
- **`DIV`=2 build.** `en`=1 → `clk_1MHz` toggles every cycle (25 MHz). `tick_1MHz` (macro defined) is high on every rising cycle.
- **Reset priority.** `rst`=1 with `en`=1 for 5 cycles → all outputs held at 0 and `cnt`=0.
